// File: rtl/interrupt_controller.sv
// Interrupt controller: latches source rising edges into IF, masks them with
// IE, and presents the highest-priority pending request and its vector to the
// CPU when the master enable IME is set.
module interrupt_controller #(
   parameter logic [15:0] IF_ADDR     = 16'hFF0F,
   parameter logic [15:0] IE_ADDR     = 16'hFFFF,
   parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        vblank_int,
   input  logic        lcdc_int,
   input  logic        timer_int,
   input  logic        serial_int,
   input  logic        joypad_int,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   input  logic        wren,
   output logic [7:0]  data_out,
   output logic        reg_sel,
   input  logic        ime_set,
   input  logic        ime_clear,
   output logic        int_req,
   output logic [15:0] int_vector,
   input  logic        int_ack,
   output logic        int_pending
);

   logic [4:0] lines;
   logic [4:0] src_q;
   logic [4:0] src_d;
   logic       armed;
   logic [4:0] src_rise;
   logic [4:0] if_flags;
   logic [4:0] if_next;
   logic [7:0] ie_reg;
   logic       ime;
   logic       ime_next;
   logic [4:0] active;
   logic [3:0] pick;
   logic       sel_vld;
   logic [2:0] sel_idx;
   logic [4:0] sel_mask;
   logic       ack_take;

   // Lowest set bit wins; result is {valid, index}.
   function automatic logic [3:0] pick_lowest(input logic [4:0] p);
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 4; i >= 0; i--) begin
         if (p[i]) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   assign lines = {joypad_int, serial_int, timer_int, lcdc_int, vblank_int};

   // Source sampling. The first sample after reset seeds both stages, so a
   // line already high when reset releases is taken as the baseline and does
   // not count as a rising edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         src_q <= 5'b0;
         src_d <= 5'b0;
         armed <= 1'b0;
      end else begin
         src_q <= lines;
         src_d <= armed ? src_q : lines;
         armed <= 1'b1;
      end
   end

   assign src_rise = src_q & ~src_d;

   // Priority selection over enabled, flagged sources (IE[7:5] never take part).
   always_comb begin
      active   = if_flags & ie_reg[4:0];
      pick     = pick_lowest(active);
      sel_vld  = pick[3];
      sel_idx  = pick[2:0];
      sel_mask = sel_vld ? (5'b00001 << sel_idx) : 5'b00000;
   end

   assign int_pending = |active;
   assign int_req     = ime & int_pending;
   assign int_vector  = sel_vld ? (VECTOR_BASE + {10'b0, sel_idx, 3'b000}) : 16'h0000;
   assign ack_take    = int_ack & int_req;

   // IF next value: CPU write, then acknowledge clear, then source edges, so a
   // new edge is never lost to a simultaneous write or ack.
   always_comb begin
      if_next = if_flags;
      if (wren && (addr == IF_ADDR)) if_next = data_in[4:0];
      if (ack_take) if_next = if_next & ~sel_mask;
      if_next = if_next | src_rise;
   end

   // IME next value: clear beats set, and taking an interrupt always clears.
   always_comb begin
      ime_next = ime;
      if (ime_set) ime_next = 1'b1;
      if (ime_clear) ime_next = 1'b0;
      if (ack_take) ime_next = 1'b0;
   end

   // Architectural register state.
   always_ff @(posedge clock) begin
      if (reset) begin
         if_flags <= 5'b0;
         ie_reg   <= 8'h00;
         ime      <= 1'b0;
      end else begin
         if_flags <= if_next;
         ime      <= ime_next;
         if (wren && (addr == IE_ADDR)) ie_reg <= data_in;
      end
   end

   // Register read port, unmapped addresses float high.
   always_comb begin
      reg_sel  = (addr == IF_ADDR) || (addr == IE_ADDR);
      data_out = 8'hFF;
      if (addr == IF_ADDR) data_out = {3'b111, if_flags};
      else if (addr == IE_ADDR) data_out = ie_reg;
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_interrupt_controller;

   localparam logic [15:0] IFA = 16'hFF0F;
   localparam logic [15:0] IEA = 16'hFFFF;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        vblank_int = 1'b0, lcdc_int = 1'b0, timer_int = 1'b0;
   logic        serial_int = 1'b0, joypad_int = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  data_in = 8'h00;
   logic        wren = 1'b0;
   logic [7:0]  data_out;
   logic        reg_sel;
   logic        ime_set = 1'b0, ime_clear = 1'b0;
   logic        int_req;
   logic [15:0] int_vector;
   logic        int_ack = 1'b0;
   logic        int_pending;

   int total = 0;
   int bad   = 0;

   interrupt_controller dut (
      .clock(clock), .reset(reset),
      .vblank_int(vblank_int), .lcdc_int(lcdc_int), .timer_int(timer_int),
      .serial_int(serial_int), .joypad_int(joypad_int),
      .addr(addr), .data_in(data_in), .wren(wren),
      .data_out(data_out), .reg_sel(reg_sel),
      .ime_set(ime_set), .ime_clear(ime_clear),
      .int_req(int_req), .int_vector(int_vector),
      .int_ack(int_ack), .int_pending(int_pending)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Flags kept as an array of bools; an edge seen between two consecutive
   // post-reset samples is posted one edge later.
   logic [4:0] m_if = '0, m_last = '0, m_post = '0;
   logic [7:0] m_ie = '0;
   logic       m_ime = 1'b0, m_last_vld = 1'b0, m_ok = 1'b0;

   function automatic int first_sel(input logic [4:0] f, input logic [7:0] e);
      for (int i = 0; i < 5; i++) if (f[i] && e[i]) return i;
      return -1;
   endfunction

   logic [4:0] n_if, n_last, n_post, cur_lines;
   logic [7:0] n_ie;
   logic       n_ime;
   int         n_s;
   always_comb begin
      cur_lines = {joypad_int, serial_int, timer_int, lcdc_int, vblank_int};
      n_s    = first_sel(m_if, m_ie);
      n_if   = m_if;
      n_ie   = m_ie;
      n_ime  = m_ime;
      if (wren && addr == IFA) n_if = data_in[4:0];
      if (wren && addr == IEA) n_ie = data_in;
      if (ime_set) n_ime = 1'b1;
      if (ime_clear) n_ime = 1'b0;
      if (int_ack && m_ime && n_s >= 0) begin
         n_if[n_s] = 1'b0;
         n_ime = 1'b0;
      end
      n_if   = n_if | m_post;
      n_post = m_last_vld ? (cur_lines & ~m_last) : 5'b0;
      n_last = cur_lines;
   end

   always @(posedge clock) begin
      if (reset) begin
         m_if <= '0; m_ie <= '0; m_ime <= 1'b0; m_post <= '0;
         m_last <= '0; m_last_vld <= 1'b0; m_ok <= 1'b1;
      end else begin
         m_if <= n_if; m_ie <= n_ie; m_ime <= n_ime; m_post <= n_post;
         m_last <= n_last; m_last_vld <= 1'b1;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      if (m_ok) begin
         int s;
         logic [15:0] ev;
         logic [7:0]  ed;
         s  = first_sel(m_if, m_ie);
         ev = (s >= 0) ? 16'(16'h0040 + 8 * s) : 16'h0000;
         ed = (addr == IFA) ? {3'b111, m_if} : (addr == IEA) ? m_ie : 8'hFF;
         chk("int_pending", {15'b0, int_pending}, {15'b0, s >= 0});
         chk("int_req", {15'b0, int_req}, {15'b0, m_ime && s >= 0});
         chk("int_vector", int_vector, ev);
         chk("reg_sel", {15'b0, reg_sel}, {15'b0, addr == IFA || addr == IEA});
         chk("data_out", {8'b0, data_out}, {8'b0, ed});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; data_in = d; wren = 1'b1;
      step();
      wren = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [15:0] a, input logic [7:0] exp);
      addr = a;
      @(negedge clock);
      chk(nm, {8'b0, data_out}, {8'b0, exp});
   endtask

   task automatic pulse_ime();
      ime_set = 1'b1;
      step();
      ime_set = 1'b0;
   endtask

   task automatic lines_off();
      {joypad_int, serial_int, timer_int, lcdc_int, vblank_int} = 5'b0;
   endtask

   initial begin
      // Reset state.
      do_reset();
      @(negedge clock);
      chk("rst_req", {15'b0, int_req}, 16'h0);
      chk("rst_pend", {15'b0, int_pending}, 16'h0);
      chk("rst_vec", int_vector, 16'h0000);
      rd("rst_if", IFA, 8'hE0);
      rd("rst_ie", IEA, 8'h00);
      rd("unmapped", 16'h1234, 8'hFF);

      // vblank edge, two cycles to request.
      step();
      wr(IEA, 8'h01);
      pulse_ime();
      vblank_int = 1'b1;
      step();
      @(negedge clock);
      chk("vb_early_req", {15'b0, int_req}, 16'h0);
      step();
      @(negedge clock);
      chk("vb_req", {15'b0, int_req}, 16'h1);
      chk("vb_vec", int_vector, 16'h0040);
      rd("vb_if", IFA, 8'hE1);
      lines_off();

      // Simultaneous timer+lcdc, ack removes lcdc only.
      do_reset();
      wr(IEA, 8'h1F);
      pulse_ime();
      timer_int = 1'b1; lcdc_int = 1'b1;
      step();
      step();
      @(negedge clock);
      chk("two_vec", int_vector, 16'h0048);
      chk("two_req", {15'b0, int_req}, 16'h1);
      step();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      @(negedge clock);
      chk("ack_req", {15'b0, int_req}, 16'h0);
      chk("ack_pend", {15'b0, int_pending}, 16'h1);
      chk("ack_vec", int_vector, 16'h0050);
      rd("ack_if", IFA, 8'hE4);
      lines_off();

      // Joypad pending without IME, then enable.
      do_reset();
      wr(IEA, 8'h10);
      joypad_int = 1'b1;
      step();
      step();
      @(negedge clock);
      chk("jp_pend", {15'b0, int_pending}, 16'h1);
      chk("jp_req", {15'b0, int_req}, 16'h0);
      step();
      pulse_ime();
      @(negedge clock);
      chk("jp_req_on", {15'b0, int_req}, 16'h1);
      chk("jp_vec", int_vector, 16'h0060);
      lines_off();

      // Serial edge survives a same-edge write of zero.
      do_reset();
      serial_int = 1'b1;
      step();
      wr(IFA, 8'h00);
      rd("ser_if", IFA, 8'hE8);
      lines_off();

      // Level held high sets IF once; ack clears it until a new rise.
      do_reset();
      wr(IEA, 8'h04);
      pulse_ime();
      timer_int = 1'b1;
      step();
      step();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      repeat (7) step();
      rd("hold_if", IFA, 8'hE0);
      step();
      timer_int = 1'b0;
      step();
      rd("fall_if", IFA, 8'hE0);
      step();
      timer_int = 1'b1;
      step();
      step();
      rd("rerise_if", IFA, 8'hE4);

      // Line held high through reset release does not post.
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      repeat (4) step();
      rd("thru_rst_if", IFA, 8'hE0);
      lines_off();

      // Reset in the middle of an active request.
      do_reset();
      wr(IEA, 8'hFF);
      wr(IFA, 8'hFF);
      pulse_ime();
      @(negedge clock);
      chk("mid_req_pre", {15'b0, int_req}, 16'h1);
      step();
      reset = 1'b1;
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      @(negedge clock);
      chk("mid_req", {15'b0, int_req}, 16'h0);
      rd("mid_if", IFA, 8'hE0);
      rd("mid_ie", IEA, 8'h00);
      step();
      reset = 1'b0;
      step();

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         logic [4:0] l;
         l = {joypad_int, serial_int, timer_int, lcdc_int, vblank_int};
         for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) l[b] = ~l[b];
         {joypad_int, serial_int, timer_int, lcdc_int, vblank_int} = l;
         case ($urandom_range(0, 3))
            0, 3: addr = IFA;
            1: addr = IEA;
            default: addr = 16'($urandom);
         endcase
         data_in   = 8'($urandom);
         wren      = ($urandom_range(0, 9) == 0);
         ime_set   = ($urandom_range(0, 5) == 0);
         ime_clear = ($urandom_range(0, 11) == 0);
         int_ack   = ($urandom_range(0, 3) == 0);
         reset     = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0; wren = 1'b0; int_ack = 1'b0; ime_set = 1'b0; ime_clear = 1'b0;
      step();
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter IF_ADDR, default 16'hFF0F, address of interrupt flag register IF.
REQ-002 Parameter IE_ADDR, default 16'hFFFF, address of interrupt enable register IE.
REQ-003 Parameter VECTOR_BASE, default 16'h0040, vector of source 0; vector spacing 8.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 vblank_int, lcdc_int, timer_int, serial_int, joypad_int  in  1 each  level request lines from the PPU, timer, serial and joypad blocks.
REQ-007 addr  in  16  CPU bus address.
REQ-008 data_in  in  8  CPU write data.
REQ-009 wren  in  1  CPU write strobe, one cycle per write.
REQ-010 data_out  out  8  register read data; combinational from addr.
REQ-011 reg_sel  out  1  high when addr equals IF_ADDR or IE_ADDR; memory read mux uses it.
REQ-012 ime_set / ime_clear  in  1 each  EI/RETI and DI strobes from the CPU.
REQ-013 int_req  out  1  interrupt request to the CPU.
REQ-014 int_vector  out  16  service address of the current highest-priority request.
REQ-015 int_ack  in  1  one-cycle CPU acknowledge of int_req.
REQ-016 int_pending  out  1  OR of (IF & IE)[4:0], independent of IME; used for HALT wake.

Function
REQ-017 IF bits 4:0 = joypad, serial, timer, lcdc, vblank (bit4..bit0); IE is a full 8-bit register; IME is a 1-bit internal flag.
REQ-018 Each source line is registered once; a 0->1 transition of the registered line sets its IF bit in the following cycle; a level held high sets the bit only once.
REQ-019 IF read returns {3'b111, IF[4:0]}; IE read returns IE[7:0]; data_out = 8'hFF when reg_sel is low.
REQ-020 Write with wren and addr==IF_ADDR loads IF[4:0] from data_in[4:0]; addr==IE_ADDR loads IE from data_in; other addresses ignored.
REQ-021 ime_set sets IME next cycle; ime_clear clears IME next cycle; both asserted in one cycle: ime_clear wins.
REQ-022 Priority: bit0 highest through bit4 lowest; selected = lowest-index set bit of (IF & IE)[4:0].
REQ-023 int_vector = VECTOR_BASE + 8*index of the selected bit (16'h0040, 0048, 0050, 0058, 0060 at default); 16'h0000 when nothing is selected.
REQ-024 int_req = IME & int_pending; combinational from registers.
REQ-025 int_ack while int_req is high clears the selected IF bit and clears IME in the same edge; int_ack while int_req is low has no effect.
REQ-026 Same-edge ordering for IF: CPU write applied first, then the ack clear, then source-edge sets; a source edge always survives a simultaneous write or ack.
REQ-027 int_ack and ime_set in the same cycle: IME ends at 0.
REQ-028 IE bits 7:5 are storage only and never affect int_pending, int_req or int_vector.

Reset
REQ-029 On reset: IF=5'b0, IE=8'h00, IME=0, edge-detect registers=0; int_req=0, int_pending=0, int_vector=16'h0000 in the cycle after reset is sampled high.
REQ-030 A source line held high through reset release does not set IF; only a later 0->1 transition does.
REQ-031 Reset overrides all same-cycle writes, acks and edges.

Verification
REQ-032 Reset, write IE=8'h01, pulse ime_set, raise vblank_int -> IF reads 8'hE1, int_req=1, int_vector=16'h0040 two cycles after the edge.
REQ-033 IE=8'h1F, IME=1, raise timer_int and lcdc_int on the same edge -> int_vector=16'h0048; int_ack -> IF reads 8'hE4, IME=0, int_req=0, int_pending=1.
REQ-034 IME=0, IE=8'h10, raise joypad_int -> int_pending=1, int_req=0; then ime_set -> int_req=1, int_vector=16'h0060.
REQ-035 Write IF=8'h00 in the same cycle the registered serial edge sets IF -> IF reads 8'hE8.
REQ-036 Hold timer_int high for 10 cycles, ack once -> IF[2] clears and stays 0 until timer_int falls and rises again.
REQ-037 Assert reset mid-request (IF=8'hFF, IE=8'hFF, IME=1) -> IF reads 8'hE0, IE reads 8'h00, int_req=0 the next cycle.
